task_cmd_dispatcher: RTL and testbench

- clkA-side producer that queues command words and issues them one at a time as single-cycle task starts into the clkA/clkB task-handshake crossing.
- Holds each command's payload stable on task_data for the whole task, so clkB logic can sample it once its start pulse arrives.
- Reports completion and timeout per task, and exposes queue occupancy to upstream.

---
 rtl/task_cmd_dispatcher.sv | 114 +++++++++++
 tb/tb_task_cmd_dispatcher.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_cmd_dispatcher.sv
// Queues upstream command words and issues them one at a time as single-cycle task starts
// into the clkA side of the clkA/clkB task-handshake crossing.
module task_cmd_dispatcher #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                     clkA,
   input  logic                     rst,
   input  logic                     cmd_valid,
   input  logic [DATA_W-1:0]        cmd_data,
   output logic                     cmd_ready,
   output logic                     task_start,
   input  logic                     task_busy,
   input  logic                     task_done,
   output logic [DATA_W-1:0]        task_data,
   output logic                     done_valid,
   output logic [DATA_W-1:0]        done_data,
   output logic                     timeout_err,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     idle
);

   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned CntW   = PtrW + 1;
   localparam int unsigned TimerW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StWait} state_t;

   state_t            state;
   logic [DATA_W-1:0] fifoMem [DEPTH];
   logic [PtrW-1:0]   wrPtr;
   logic [PtrW-1:0]   rdPtr;
   logic [TimerW-1:0] timer;
   logic              push;
   logic              pop;

   assign cmd_ready = (fifo_count < CntW'(DEPTH));
   assign push      = cmd_valid & cmd_ready;
   // The only pop point is the IDLE->START transition, gated by a quiet crossing.
   assign pop       = (state == StIdle) & (fifo_count != '0) & ~task_busy;
   assign idle      = (fifo_count == '0) & (state == StIdle) & ~task_busy;

   always_ff @(posedge clkA) begin
      if (push) begin
         fifoMem[wrPtr] <= cmd_data;
      end
   end

   always_ff @(posedge clkA or posedge rst) begin
      if (rst) begin
         wrPtr      <= '0;
         rdPtr      <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clkA or posedge rst) begin
      if (rst) begin
         state       <= StIdle;
         task_start  <= 1'b0;
         task_data   <= '0;
         done_valid  <= 1'b0;
         done_data   <= '0;
         timeout_err <= 1'b0;
         timer       <= '0;
      end else begin
         task_start  <= 1'b0;
         done_valid  <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            StIdle: begin
               if (pop) begin
                  task_data  <= fifoMem[rdPtr];
                  task_start <= 1'b1;
                  state      <= StStart;
               end
            end
            StStart: begin
               timer <= '0;
               state <= StWait;
            end
            StWait: begin
               // Completion takes priority over a timeout landing in the same cycle.
               if (task_done) begin
                  done_valid <= 1'b1;
                  done_data  <= task_data;
                  state      <= StIdle;
               end else if ((TIMEOUT != 0) && (timer == TimerLast)) begin
                  timeout_err <= 1'b1;
                  state       <= StIdle;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_task_cmd_dispatcher.sv
// Directed bench for task_cmd_dispatcher; one instance at the default TIMEOUT and one at
// TIMEOUT = 8, each with the crossing modelled by hand-driven busy/done.
module tb_task_cmd_dispatcher;

   logic clkA = 1'b0;
   logic rst;
   always #5 clkA = ~clkA;

   logic        cmdValid, cmdReady, taskStart, taskBusy, taskDone, doneValid, timeoutErr, idle;
   logic [15:0] cmdData, taskData, doneData;
   logic [2:0]  fifoCount;

   logic        tCmdValid, tCmdReady, tTaskStart, tTaskBusy, tTaskDone, tDoneValid;
   logic        tTimeoutErr, tIdle;
   logic [15:0] tCmdData, tTaskData, tDoneData;
   logic [2:0]  tFifoCount;

   int checks = 0;
   int errors = 0;

   task_cmd_dispatcher #(.DATA_W(16), .DEPTH(4), .TIMEOUT(1023)) u_dut (
      .clkA(clkA), .rst(rst), .cmd_valid(cmdValid), .cmd_data(cmdData), .cmd_ready(cmdReady),
      .task_start(taskStart), .task_busy(taskBusy), .task_done(taskDone), .task_data(taskData),
      .done_valid(doneValid), .done_data(doneData), .timeout_err(timeoutErr),
      .fifo_count(fifoCount), .idle(idle)
   );

   task_cmd_dispatcher #(.DATA_W(16), .DEPTH(4), .TIMEOUT(8)) u_dut_to (
      .clkA(clkA), .rst(rst), .cmd_valid(tCmdValid), .cmd_data(tCmdData), .cmd_ready(tCmdReady),
      .task_start(tTaskStart), .task_busy(tTaskBusy), .task_done(tTaskDone),
      .task_data(tTaskData), .done_valid(tDoneValid), .done_data(tDoneData),
      .timeout_err(tTimeoutErr), .fifo_count(tFifoCount), .idle(tIdle)
   );

   task automatic tick();
      @(posedge clkA);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmdValid = 1'b0; cmdData = '0; taskBusy = 1'b0; taskDone = 1'b0;
      tCmdValid = 1'b0; tCmdData = '0; tTaskBusy = 1'b0; tTaskDone = 1'b0;
      repeat (3) tick();
      checks++;
      if ({cmdReady, taskStart, doneValid, timeoutErr, idle} !== 5'b10001) begin
         errors++;
         $display("FAIL reset_flags: got %b exp 10001",
                  {cmdReady, taskStart, doneValid, timeoutErr, idle});
      end
      checks++;
      if (fifoCount !== 3'd0 || taskData !== 16'h0 || doneData !== 16'h0) begin
         errors++;
         $display("FAIL reset_values: got count=%0d task=%h done=%h exp 0 0000 0000",
                  fifoCount, taskData, doneData);
      end
      checks++;
      if ({tCmdReady, tTaskStart, tDoneValid, tTimeoutErr, tIdle, tFifoCount} !== 8'b10001_000)
      begin
         errors++;
         $display("FAIL reset_to_inst: got %b exp 10001000",
                  {tCmdReady, tTaskStart, tDoneValid, tTimeoutErr, tIdle, tFifoCount});
      end
      rst = 1'b0;
      repeat (2) tick();
      checks++;
      if (taskStart !== 1'b0 || fifoCount !== 3'd0) begin
         errors++;
         $display("FAIL reset_release: got start=%b count=%0d exp 0 0", taskStart, fifoCount);
      end
   endtask

   task automatic test_single();
      cmdValid = 1'b1; cmdData = 16'h1234;
      tick();
      cmdValid = 1'b0;
      checks++;
      if (fifoCount !== 3'd1 || taskStart !== 1'b0) begin
         errors++;
         $display("FAIL single_accept: got count=%0d start=%b exp 1 0", fifoCount, taskStart);
      end
      tick();
      checks++;
      if (taskStart !== 1'b1 || taskData !== 16'h1234 || fifoCount !== 3'd0) begin
         errors++;
         $display("FAIL single_start: got start=%b data=%h count=%0d exp 1 1234 0",
                  taskStart, taskData, fifoCount);
      end
      tick();
      taskBusy = 1'b1;
      checks++;
      if (taskStart !== 1'b0) begin
         errors++;
         $display("FAIL single_start_pulse: got %b exp 0", taskStart);
      end
      repeat (4) tick();
      checks++;
      if (taskData !== 16'h1234 || idle !== 1'b0 || doneValid !== 1'b0) begin
         errors++;
         $display("FAIL single_wait: got data=%h idle=%b done=%b exp 1234 0 0",
                  taskData, idle, doneValid);
      end
      taskDone = 1'b1; taskBusy = 1'b0;
      tick();
      taskDone = 1'b0;
      checks++;
      if (doneValid !== 1'b1 || doneData !== 16'h1234 || idle !== 1'b1) begin
         errors++;
         $display("FAIL single_done: got valid=%b data=%h idle=%b exp 1 1234 1",
                  doneValid, doneData, idle);
      end
      tick();
      checks++;
      if (doneValid !== 1'b0 || taskData !== 16'h1234) begin
         errors++;
         $display("FAIL single_done_pulse: got valid=%b data=%h exp 0 1234", doneValid, taskData);
      end
   endtask

   task automatic test_fifo_full();
      logic [15:0] vals [5] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
      logic [15:0] got [$];
      int  starts, stalls, i, guard, w;
      bit  ok, sawFull, fullReady, overCount, stuck;
      starts = 0; stalls = 0; i = 0; guard = 0;
      sawFull = 0; fullReady = 0; overCount = 0; stuck = 0;
      taskBusy = 1'b1;
      fork
         begin
            while (i < 5 && guard < 100) begin
               cmdValid = 1'b1; cmdData = vals[i]; ok = cmdReady;
               tick();
               guard++;
               if (ok) i++;
               else stalls++;
            end
            cmdValid = 1'b0;
         end
         begin
            repeat (6) tick();
            taskBusy = 1'b0;
            for (int t = 0; t < 5; t++) begin
               w = 0;
               while (!taskStart && w < 100) begin
                  tick();
                  w++;
               end
               if (w == 100) stuck = 1;
               tick();
               taskBusy = 1'b1;
               repeat (19) tick();
               taskDone = 1'b1; taskBusy = 1'b0;
               tick();
               taskDone = 1'b0;
            end
         end
         begin
            for (int c = 0; c < 400 && got.size() < 5; c++) begin
               tick();
               if (taskStart) starts++;
               if (fifoCount == 3'd4) begin
                  sawFull = 1;
                  if (cmdReady !== 1'b0) fullReady = 1;
               end
               if (fifoCount > 3'd4) overCount = 1;
               if (doneValid) got.push_back(doneData);
            end
         end
      join
      checks++;
      if (stuck) begin
         errors++;
         $display("FAIL full_model_wait: got no task_start within bound exp start");
      end
      checks++;
      if (!sawFull || fullReady || overCount) begin
         errors++;
         $display("FAIL full_ready: got sawFull=%b readyWhileFull=%b over=%b exp 1 0 0",
                  sawFull, fullReady, overCount);
      end
      checks++;
      if (stalls != 3) begin
         errors++;
         $display("FAIL full_stalls: got %0d exp 3", stalls);
      end
      checks++;
      if (starts != 5 || got.size() != 5) begin
         errors++;
         $display("FAIL full_counts: got starts=%0d dones=%0d exp 5 5", starts, got.size());
      end
      for (int k = 0; k < got.size() && k < 5; k++) begin
         checks++;
         if (got[k] !== vals[k]) begin
            errors++;
            $display("FAIL full_order[%0d]: got %h exp %h", k, got[k], vals[k]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [15:0] vals [8] = '{16'hB000, 16'hB001, 16'hB002, 16'hB003,
                                16'hB004, 16'hB005, 16'hB006, 16'hB007};
      logic [15:0] got [$];
      int  i, guard, w;
      bit  ok, stuck;
      i = 3; guard = 0; stuck = 0;
      taskBusy = 1'b1;
      cmdValid = 1'b1; cmdData = vals[0];
      tick();
      cmdData = vals[1];
      tick();
      checks++;
      if (fifoCount !== 3'd2) begin
         errors++;
         $display("FAIL wrap_prefill: got count=%0d exp 2", fifoCount);
      end
      cmdData = vals[2]; taskBusy = 1'b0;
      tick();
      checks++;
      if (fifoCount !== 3'd2 || taskStart !== 1'b1 || taskData !== vals[0]) begin
         errors++;
         $display("FAIL wrap_push_pop: got count=%0d start=%b data=%h exp 2 1 %h",
                  fifoCount, taskStart, taskData, vals[0]);
      end
      fork
         begin
            while (i < 8 && guard < 200) begin
               cmdValid = 1'b1; cmdData = vals[i]; ok = cmdReady;
               tick();
               guard++;
               if (ok) i++;
            end
            cmdValid = 1'b0;
         end
         begin
            for (int t = 0; t < 8; t++) begin
               w = 0;
               while (!taskStart && w < 100) begin
                  tick();
                  w++;
               end
               if (w == 100) stuck = 1;
               tick();
               taskBusy = 1'b1;
               tick();
               taskDone = 1'b1; taskBusy = 1'b0;
               tick();
               taskDone = 1'b0;
            end
         end
         begin
            for (int c = 0; c < 400 && got.size() < 8; c++) begin
               tick();
               if (doneValid) got.push_back(doneData);
            end
         end
      join
      cmdValid = 1'b0;
      checks++;
      if (stuck || got.size() != 8) begin
         errors++;
         $display("FAIL wrap_count: got dones=%0d stuck=%b exp 8 0", got.size(), stuck);
      end
      for (int k = 0; k < got.size() && k < 8; k++) begin
         checks++;
         if (got[k] !== vals[k]) begin
            errors++;
            $display("FAIL wrap_order[%0d]: got %h exp %h", k, got[k], vals[k]);
         end
      end
   endtask

   task automatic test_timeout();
      bit sawStart;
      tCmdValid = 1'b1; tCmdData = 16'hBEEF;
      tick();
      tCmdValid = 1'b0;
      tick();
      checks++;
      if (tTaskStart !== 1'b1 || tTaskData !== 16'hBEEF) begin
         errors++;
         $display("FAIL to_start: got start=%b data=%h exp 1 beef", tTaskStart, tTaskData);
      end
      tick();
      tTaskBusy = 1'b1;
      repeat (7) tick();
      checks++;
      if (tTimeoutErr !== 1'b0) begin
         errors++;
         $display("FAIL to_early: got timeout=%b exp 0 at 8 cycles after start", tTimeoutErr);
      end
      tick();
      checks++;
      if (tTimeoutErr !== 1'b1 || tDoneValid !== 1'b0) begin
         errors++;
         $display("FAIL to_pulse: got timeout=%b done=%b exp 1 0", tTimeoutErr, tDoneValid);
      end
      tCmdValid = 1'b1; tCmdData = 16'hCAFE;
      tick();
      tCmdValid = 1'b0;
      checks++;
      if (tTimeoutErr !== 1'b0) begin
         errors++;
         $display("FAIL to_one_pulse: got %b exp 0", tTimeoutErr);
      end
      sawStart = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (tTaskStart) sawStart = 1;
      end
      checks++;
      if (sawStart || tFifoCount !== 3'd1) begin
         errors++;
         $display("FAIL to_wait_busy: got start=%b count=%0d exp 0 1", sawStart, tFifoCount);
      end
      tTaskDone = 1'b1;
      tick();
      tTaskDone = 1'b0;
      checks++;
      if (tDoneValid !== 1'b0) begin
         errors++;
         $display("FAIL to_stray_idle: got done_valid=%b exp 0", tDoneValid);
      end
      tTaskBusy = 1'b0;
      tick();
      checks++;
      if (tTaskStart !== 1'b1 || tTaskData !== 16'hCAFE) begin
         errors++;
         $display("FAIL to_restart: got start=%b data=%h exp 1 cafe", tTaskStart, tTaskData);
      end
      tTaskDone = 1'b1;
      tick();
      tTaskDone = 1'b0;
      checks++;
      if (tDoneValid !== 1'b0 || tIdle !== 1'b0) begin
         errors++;
         $display("FAIL to_stray_start: got done_valid=%b idle=%b exp 0 0", tDoneValid, tIdle);
      end
      tTaskDone = 1'b1;
      tick();
      tTaskDone = 1'b0;
      checks++;
      if (tDoneValid !== 1'b1 || tDoneData !== 16'hCAFE) begin
         errors++;
         $display("FAIL to_done_after: got valid=%b data=%h exp 1 cafe", tDoneValid, tDoneData);
      end
   endtask

   task automatic test_done_vs_timeout();
      tCmdValid = 1'b1; tCmdData = 16'h5A5A;
      tick();
      tCmdValid = 1'b0;
      tick();
      checks++;
      if (tTaskStart !== 1'b1) begin
         errors++;
         $display("FAIL race_start: got %b exp 1", tTaskStart);
      end
      tick();
      tTaskBusy = 1'b1;
      repeat (7) tick();
      tTaskDone = 1'b1; tTaskBusy = 1'b0;
      tick();
      tTaskDone = 1'b0;
      checks++;
      if (tDoneValid !== 1'b1 || tTimeoutErr !== 1'b0 || tDoneData !== 16'h5A5A) begin
         errors++;
         $display("FAIL race_done_wins: got valid=%b timeout=%b data=%h exp 1 0 5a5a",
                  tDoneValid, tTimeoutErr, tDoneData);
      end
      tick();
      checks++;
      if (tTimeoutErr !== 1'b0 || tIdle !== 1'b1) begin
         errors++;
         $display("FAIL race_after: got timeout=%b idle=%b exp 0 1", tTimeoutErr, tIdle);
      end
   endtask

   task automatic test_reset_mid();
      bit sawStart;
      cmdValid = 1'b1; cmdData = 16'hD00D;
      tick();
      cmdValid = 1'b0;
      tick();
      tick();
      taskBusy = 1'b1;
      cmdValid = 1'b1; cmdData = 16'hE001;
      tick();
      cmdData = 16'hE002;
      tick();
      cmdValid = 1'b0;
      checks++;
      if (fifoCount !== 3'd2 || taskData !== 16'hD00D || idle !== 1'b0) begin
         errors++;
         $display("FAIL rmid_setup: got count=%0d data=%h idle=%b exp 2 d00d 0",
                  fifoCount, taskData, idle);
      end
      #2;
      rst = 1'b1; taskBusy = 1'b0;
      #1;
      checks++;
      if ({cmdReady, taskStart, doneValid, timeoutErr, idle} !== 5'b10001) begin
         errors++;
         $display("FAIL rmid_flags: got %b exp 10001",
                  {cmdReady, taskStart, doneValid, timeoutErr, idle});
      end
      checks++;
      if (fifoCount !== 3'd0 || taskData !== 16'h0 || doneData !== 16'h0) begin
         errors++;
         $display("FAIL rmid_values: got count=%0d task=%h done=%h exp 0 0000 0000",
                  fifoCount, taskData, doneData);
      end
      repeat (2) tick();
      rst = 1'b0;
      sawStart = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (taskStart || doneValid) sawStart = 1;
      end
      checks++;
      if (sawStart || fifoCount !== 3'd0 || idle !== 1'b1) begin
         errors++;
         $display("FAIL rmid_quiet: got activity=%b count=%0d idle=%b exp 0 0 1",
                  sawStart, fifoCount, idle);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fifo_full();
      test_wrap();
      test_timeout();
      test_done_vs_timeout();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
